// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register bank with one byte-enabled write port
// and two registered read ports (one cycle read latency).
//
// Optional build macro: REGFILE_BYPASS_EN
//   undefined (default): a read that hits the word being written on the same
//                        edge returns the old stored word.
//   defined:             that read returns the merged word (written bytes from
//                        wdata, untouched bytes from the stored word).
// Storage contents after each edge are the same in both builds.
//
// Handshake: there is none. we/re_a/re_b are single-cycle strobes sampled on
// every rising clk edge with no back-pressure. A read issued on edge N shows
// its data on rdata_x from edge N until the next edge with re_x=1.
//
// There is no FSM. The observable state is the storage array plus the two
// read data registers, and both read outputs are those registers directly.

module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic                 re_a,
    input  logic [AW-1:0]        raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic                 re_b,
    input  logic [AW-1:0]        raddr_b,
    output logic [WIDTH-1:0]     rdata_b
);

    localparam int NB = WIDTH / 8;
    // DEPTH may equal 2**AW, so the range compare needs one extra bit.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    // Storage is packed so reset and update are whole-array assignments.
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;

    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q;
    logic [WIDTH-1:0] rdata_b_d;

    logic             wr_valid;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] rd_word_a;
    logic [WIDTH-1:0] rd_word_b;

    // An address refers to real, writable/readable storage: inside DEPTH and
    // not the hardwired zero word.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        logic in_range;
        logic is_zero_word;
        in_range     = ({1'b0, addr} < DEPTH_W);
        is_zero_word = (ZERO_REG != 0) && (addr == '0);
        return in_range && !is_zero_word;
    endfunction

    // Write decode: qualify the write and build the byte-merged word.
    always_comb begin
        wr_valid = we && (|wbe) && addr_ok(waddr);
        wr_old   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
                wr_old = mem_q[i];
            end
        end
        wr_merged = wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
                wr_merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Next storage state: only the addressed word changes, and only for a
    // qualified write.
    always_comb begin
        mem_d = mem_q;
        if (wr_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    mem_d[i] = wr_merged;
                end
            end
        end
    end

    // Port A read mux: stored word, forced to zero for out-of-range or the
    // hardwired zero word, optionally replaced by the word being written.
    always_comb begin
        rd_word_a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                rd_word_a = mem_q[i];
            end
        end
        if (!addr_ok(raddr_a)) begin
            rd_word_a = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (raddr_a == waddr)) begin
            rd_word_a = wr_merged;
        end
`endif
        rdata_a_d = re_a ? rd_word_a : rdata_a_q;
    end

    // Port B read mux: same rules as port A, fully independent.
    always_comb begin
        rd_word_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_b == AW'(i)) begin
                rd_word_b = mem_q[i];
            end
        end
        if (!addr_ok(raddr_b)) begin
            rd_word_b = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (raddr_b == waddr)) begin
            rd_word_b = wr_merged;
        end
`endif
        rdata_b_d = re_b ? rd_word_b : rdata_b_q;
    end

    // Storage register: cleared asynchronously, updated on every clk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read data registers: cleared asynchronously, hold when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w. Two instances share one stimulus stream:
//   u_dut0: DEPTH=8, ZERO_REG=0 (default configuration)
//   u_dut1: DEPTH=6, ZERO_REG=1 (boundary configuration)
// Build with +define+REGFILE_BYPASS_EN to check the forwarding build.

module tb_regfile_2r1w;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        re_a;
  logic [2:0]  raddr_a;
  logic        re_b;
  logic [2:0]  raddr_b;
  logic [31:0] rdata_a0;
  logic [31:0] rdata_b0;
  logic [31:0] rdata_a1;
  logic [31:0] rdata_b1;

  regfile_2r1w #(.WIDTH(32), .DEPTH(8), .AW(3), .ZERO_REG(0)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .wbe     (wbe),
    .re_a    (re_a),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a0),
    .re_b    (re_b),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b0)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(6), .AW(3), .ZERO_REG(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .wbe     (wbe),
    .re_a    (re_a),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a1),
    .re_b    (re_b),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b1)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [2][8];
  logic [31:0] last_a [2];
  logic [31:0] last_b [2];
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_depth(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic mdl_ok(input int k, input logic [2:0] a);
    return (int'(a) < mdl_depth(k)) && !((k == 1) && (a == 3'd0));
  endfunction

  function automatic logic [31:0] mdl_merge(input int k, input logic [2:0] a,
                                            input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = model_mem[k][a];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] mdl_read(input int k, input logic [2:0] a,
                                           input logic w, input logic [2:0] wa,
                                           input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = mdl_ok(k, a) ? model_mem[k][a] : 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (w && (be != 4'h0) && mdl_ok(k, wa) && (wa == a)) r = mdl_merge(k, wa, wd, be);
`else
    if (w && (wa == a)) r = r;  // old word is returned in this build
`endif
    return r;
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) model_mem[k][i] = 32'h0;
      last_a[k] = 32'h0;
      last_b[k] = 32'h0;
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of stimulus, push expected outputs, clock it, compare.
  task automatic step(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic ea, input logic [2:0] ra,
                      input logic eb, input logic [2:0] rb, input string tag);
    logic [31:0] obs;
    logic [31:0] exp;
    we = w; waddr = wa; wdata = wd; wbe = be;
    re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
    for (int k = 0; k < 2; k++) begin
      if (ea) last_a[k] = mdl_read(k, ra, w, wa, wd, be);
      if (eb) last_b[k] = mdl_read(k, rb, w, wa, wd, be);
      exp_q.push_back(last_a[k]);
      exp_q.push_back(last_b[k]);
    end
    for (int k = 0; k < 2; k++) begin
      if (w && (be != 4'h0) && mdl_ok(k, wa)) model_mem[k][wa] = mdl_merge(k, wa, wd, be);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: obs = rdata_a0;
        1: obs = rdata_b0;
        2: obs = rdata_a1;
        default: obs = rdata_b1;
      endcase
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s_p%0d observed=%h expected=<empty queue>", tag, p, obs);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("%s_p%0d", tag, p), obs, exp);
      end
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = 3'd0; wdata = 32'h0; wbe = 4'h0;
    re_a = 1'b0; raddr_a = 3'd0; re_b = 1'b0; raddr_b = 3'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a0"}, rdata_a0, 32'h0);
    check({tag, "_b0"}, rdata_b0, 32'h0);
    check({tag, "_a1"}, rdata_a1, 32'h0);
    check({tag, "_b1"}, rdata_b1, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    mdl_clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;

    // Full-word write, one-cycle read, hold when re=0.
    step(1, 3'd3, 32'hfe34c213, 4'hF, 0, 3'd0, 0, 3'd0, "wr3");
    step(0, 3'd0, 32'h0,        4'h0, 1, 3'd3, 0, 3'd0, "rd3");
    step(0, 3'd0, 32'h0,        4'h0, 0, 3'd1, 0, 3'd0, "hold3");

    // Byte enables and the wbe=0 no-op.
    step(1, 3'd2, 32'hffffffff, 4'hF, 0, 3'd0, 0, 3'd0, "wr2_ones");
    step(1, 3'd2, 32'h12345678, 4'h5, 0, 3'd0, 0, 3'd0, "wr2_be5");
    step(0, 3'd0, 32'h0,        4'h0, 1, 3'd2, 1, 3'd2, "rd2_be5");
    step(1, 3'd2, 32'h00000000, 4'h0, 0, 3'd0, 0, 3'd0, "wr2_be0");
    step(0, 3'd0, 32'h0,        4'h0, 1, 3'd2, 0, 3'd0, "rd2_be0");

    // Read-during-write on the same address.
    step(1, 3'd5, 32'h00000002, 4'hF, 0, 3'd0, 0, 3'd0, "wr5");
    step(1, 3'd5, 32'hdeadbeef, 4'hF, 1, 3'd5, 1, 3'd5, "rdw5");
    step(0, 3'd0, 32'h0,        4'h0, 1, 3'd5, 0, 3'd0, "rd5_after");
    step(1, 3'd4, 32'hcafe0000, 4'h3, 1, 3'd4, 0, 3'd0, "rdw4_partial");

    // Boundaries: word 0 and the address past DEPTH.
    step(1, 3'd0, 32'hffffffff, 4'hF, 0, 3'd0, 0, 3'd0, "wr0");
    step(1, 3'd7, 32'hffffffff, 4'hF, 0, 3'd0, 0, 3'd0, "wr7");
    for (int r = 0; r < 8; r++) begin
      step(0, 3'd0, 32'h0, 4'h0, 1, 3'(r), 1, 3'(r), $sformatf("bound_rd%0d", r));
    end

    // Async reset between edges with non-zero outputs.
    step(0, 3'd0, 32'h0, 4'h0, 1, 3'd3, 1, 3'd2, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    mdl_clear();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      step(0, 3'd0, 32'h0, 4'h0, 1, 3'(r), 1, 3'(7 - r), $sformatf("post_rst_rd%0d", r));
    end

    // Reset asserted on the same edge as a write.
    step(1, 3'd1, 32'haaaa5555, 4'hF, 0, 3'd0, 0, 3'd0, "wr1_pre");
    step(0, 3'd0, 32'h0,        4'h0, 1, 3'd1, 1, 3'd1, "rd1_pre");
    we = 1'b1; waddr = 3'd1; wdata = 32'h2; wbe = 4'hF;
    re_a = 1'b1; raddr_a = 3'd1; re_b = 1'b1; raddr_b = 3'd3;
    #8;
    rst = 1'b1;
    mdl_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    check_all_zero("rst_edge_wr");
    step(0, 3'd0, 32'h0, 4'h0, 1, 3'd1, 0, 3'd0, "rd1_after_rst");
    step(1, 3'd1, 32'h2, 4'hF, 0, 3'd0, 0, 3'd0, "wr1_after_rst");
    step(0, 3'd0, 32'h0, 4'h0, 1, 3'd1, 1, 3'd1, "rd1_new");

    // Random mix of reads and writes.
    for (int n = 0; n < 60; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $sformatf("rand%0d", n));
    end

    idle();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register bank that generalises the single 32-bit reset register into DEPTH words of WIDTH bits. It has one write port with byte enables and two synchronous read ports. It serves as the general-purpose register storage for datapath blocks, with an optional hardwired-zero entry and optional write-to-read forwarding.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 8, number of words; need not be a power of two
AW, 3, address width; must satisfy 2**AW >= DEPTH
ZERO_REG, 0, when 1, word 0 always reads 0 and ignores writes

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
we  input  1  write enable
waddr  input  AW  write address
wdata  input  WIDTH  write data
wbe  input  WIDTH/8  byte enables for the write; bit i covers wdata[8i+7:8i]
re_a  input  1  read enable, port A
raddr_a  input  AW  read address, port A
rdata_a  output  WIDTH  registered read data, port A
re_b  input  1  read enable, port B
raddr_b  input  AW  read address, port B
rdata_b  output  WIDTH  registered read data, port B

Behaviour:
- Reset: on rst rising, immediately and without waiting for clk: all DEPTH words = 0; rdata_a = 0; rdata_b = 0. While rst is high, writes and reads have no effect.
- Reset mid-operation: any write or read sampled on the same edge while rst is high is discarded. Storage and outputs stay at 0 until the first clk edge with rst low.
- Write: on a clk edge with we=1, waddr<DEPTH and any wbe bit set, each byte i with wbe[i]=1 takes wdata's byte i. Bytes with wbe[i]=0 keep their old value.
- Write no-ops: we=1 with wbe=0 changes nothing. waddr>=DEPTH is ignored. When ZERO_REG=1, waddr=0 is ignored.
- Read: on a clk edge with re_x=1, rdata_x takes mem[raddr_x]. Latency is exactly 1 cycle. With re_x=0, rdata_x holds its previous value.
- Read special cases: raddr_x>=DEPTH loads 0. When ZERO_REG=1, raddr_x=0 loads 0.
- Both ports may read the same address on the same edge; both get identical data.
- Read-during-write to the same address on the same edge: without the optional feature, rdata returns the OLD stored word.
- No internal FSM. The state is the storage array plus the two output registers. Simultaneous operations on different addresses are independent.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: when a read on port x and a valid, non-ignored write hit the same address on the same edge, rdata_x returns the merged word. Bytes with wbe[i]=1 come from wdata; the rest come from the old stored word.
- Defined, write ignored: if the write is ignored (out of range, ZERO_REG word 0, or wbe=0), rdata_x returns the stored value.
- Not defined: read-during-write returns the old value, as in Behaviour.
- Storage contents after the edge are identical in both builds.

Test Plan:
1. Async reset: after preloading non-zero data, assert rst between clk edges -> rdata_a=rdata_b=0 before the next edge. Deassert, then read all addresses -> every word 32'h00000000.
2. Full write/read: write 32'hfe34c213 to addr 3 with wbe=4'hF; next cycle set re_a=1, raddr_a=3 -> rdata_a=32'hfe34c213 exactly one edge later. With re_a=0 on the following edge -> rdata_a holds.
3. Byte enables: addr 2 holds 32'hffffffff; write 32'h12345678 with wbe=4'b0101 -> read gives 32'hff34ff78. Write with wbe=0 -> word unchanged.
4. Read-during-write: addr 5 holds 32'h00000002; on one edge write 32'hdeadbeef to 5 and read port A at 5. Without REGFILE_BYPASS_EN -> 32'h00000002. With REGFILE_BYPASS_EN -> 32'hdeadbeef. Either build, next read -> 32'hdeadbeef.
5. Boundaries, with DEPTH=6 and ZERO_REG=1: write 32'hffffffff to addr 0 and to addr 7 -> addr 0 reads 0, addr 7 reads 0, addrs 1..5 unchanged. Port A and port B reading addr 4 on the same edge -> identical data.
6. Reset mid-operation: assert rst on the same edge as a write of 32'h2 to addr 1 -> after deassert, addr 1 reads 0. The first write after deassert succeeds.
